// File: rtl/iir_biquad_mux.sv
// Cascade of NSECT direct-form-I biquads sharing one signed MAC, coefficients written at runtime.
// Define IIR_SAT_EN to clamp each section output and raise the sticky sat flag; otherwise outputs wrap.
module iir_biquad_mux #(
    parameter int DW    = 12,
    parameter int CW    = 12,
    parameter int FRAC  = 11,
    parameter int NSECT = 2,
    parameter int CAW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [DW-1:0]  din,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic signed [DW-1:0]  dout,
    output logic                  out_valid,
    input  logic                  clr,
    input  logic                  coef_we,
    input  logic [CAW-1:0]        coef_addr,
    input  logic signed [CW-1:0]  coef_din,
    output logic                  overrun,
    output logic                  sat
);
    localparam int PW  = DW + CW;
    localparam int AW  = DW + CW + 3;
    localparam int SW  = (NSECT > 1) ? $clog2(NSECT) : 1;
    localparam int NC  = 5 * NSECT;
    localparam int CIW = $clog2(NC);
    localparam logic [CAW:0] NCOEF = (CAW+1)'(NC);

    typedef enum logic [1:0] {IDLE, MAC, UPD, OUT} state_t;

    state_t                    state, state_nx;
    logic [SW-1:0]             sect;
    logic [2:0]                tap;
    logic signed [DW-1:0]      xin;
    logic [NSECT-1:0][DW-1:0]  x1, x2, y1, y2;
    logic [NC-1:0][CW-1:0]     coef;
    logic signed [AW-1:0]      acc;
    logic [CIW-1:0]            cidx;
    logic signed [DW-1:0]      opx;
    logic signed [CW-1:0]      opc;
    logic signed [PW-1:0]      prod;
    logic signed [DW-1:0]      y;
    logic                      last;

    assign last = (sect == SW'(NSECT - 1));

    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nx = MAC;
            end
            MAC:  if (tap == 3'd4) state_nx = MAC == MAC ? UPD : UPD;
            UPD:  state_nx = last ? OUT : MAC;
            OUT: begin
                out_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (clr) state_nx = IDLE;
    end

    // Operand select for the shared multiplier: tap order b0,b1,b2,a1,a2.
    always_comb begin
        cidx = CIW'(5 * int'(sect) + int'(tap));
        opc  = coef[cidx];
        unique case (tap)
            3'd0:    opx = xin;
            3'd1:    opx = x1[sect];
            3'd2:    opx = x2[sect];
            3'd3:    opx = y1[sect];
            default: opx = y2[sect];
        endcase
        prod = PW'(opx) * PW'(opc);
    end

`ifdef IIR_SAT_EN
    localparam logic signed [AW-1:0] YMAX = AW'(2**(DW-1) - 1);
    localparam logic signed [AW-1:0] YMIN = AW'(-(2**(DW-1)));
    logic signed [AW-1:0] ysh;
    logic                 clip;

    always_comb begin
        ysh  = acc >>> FRAC;
        clip = 1'b1;
        if (ysh > YMAX)      y = YMAX[DW-1:0];
        else if (ysh < YMIN) y = YMIN[DW-1:0];
        else begin
            y    = ysh[DW-1:0];
            clip = 1'b0;
        end
    end
`else
    // Low DW bits of acc >>> FRAC, i.e. two's-complement wrap after the floor shift.
    assign y   = acc[FRAC +: DW];
    assign sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sect    <= '0;
            tap     <= '0;
            xin     <= '0;
            x1      <= '0;
            x2      <= '0;
            y1      <= '0;
            y2      <= '0;
            coef    <= '0;
            acc     <= '0;
            dout    <= '0;
            overrun <= 1'b0;
`ifdef IIR_SAT_EN
            sat     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (clr) begin
                x1   <= '0;
                x2   <= '0;
                y1   <= '0;
                y2   <= '0;
                sect <= '0;
                tap  <= '0;
            end else begin
                if (in_valid && state != IDLE) overrun <= 1'b1;
                unique case (state)
                    IDLE: begin
                        // Write lands before the sample's MAC reads it, so a same-cycle sample sees it.
                        if (coef_we && ({1'b0, coef_addr} < NCOEF))
                            coef[coef_addr[CIW-1:0]] <= coef_din;
                        if (in_valid) begin
                            xin  <= din;
                            sect <= '0;
                            tap  <= '0;
                        end
                    end
                    MAC: begin
                        acc <= (tap == 3'd0) ? AW'(prod) : acc + AW'(prod);
                        tap <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
                    end
                    UPD: begin
                        x2[sect] <= x1[sect];
                        x1[sect] <= xin;
                        y2[sect] <= y1[sect];
                        y1[sect] <= y;
                        xin      <= y;
                        if (last) dout <= y;
                        else      sect <= sect + SW'(1);
`ifdef IIR_SAT_EN
                        if (clip) sat <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
